// File: rtl/ultrasonic_range_ctrl.sv
// ultrasonic_range_ctrl
// Runs one HC-SR04-style ranging cycle: a trigger pulse, a wait for the echo,
// timing of the echo width, then a holdoff period. The HPS starts a cycle with
// a single-shot edge on cmd[0] or keeps cycles running with cmd[1]. The result
// is an 8-bit distance in cm, plus valid/timeout/busy status bits.
module ultrasonic_range_ctrl #(
   parameter int TRIG_CYCLES    = 500,
   parameter int CYCLES_PER_CM  = 2900,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int HOLDOFF_CYCLES = 3000000
) (
   input  logic       CLOCK_50,
   input  logic       rst,
   input  logic [7:0] cmd,
   input  logic       echo,
   output logic       trig,
   output logic [7:0] distance,
   output logic       valid,
   output logic       timeout,
   output logic       busy
);

   // One shared counter times the trigger, the echo wait, the echo-high
   // limit and the holdoff. It is one bit wider than the largest of those
   // limits, so it cannot wrap before it reaches its compare value.
   localparam int MAX_A = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
   localparam int MAX_P = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
   localparam int CNT_W = $clog2(MAX_P) + 1;
   localparam int PRE_W = $clog2(CYCLES_PER_CM) + 1;

   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(CYCLES_PER_CM - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TRIG = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_MEAS = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [PRE_W-1:0] pre;
   logic [7:0]       cm;

   logic echo_p0;
   logic echo_p1;
   logic echo_s;
   logic cmd0_q;
   logic start_pulse;
   logic go;
   logic unused_cmd;

   // Increments the centimetre count and holds it at 255 once it gets there.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // The two-flop synchroniser for the asynchronous echo pin, and the
   // cmd[0] history register used to find the start edge.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         echo_p0 <= 1'b0;
         echo_p1 <= 1'b0;
         cmd0_q  <= 1'b0;
      end else begin
         echo_p0 <= echo;
         echo_p1 <= echo_p0;
         cmd0_q  <= cmd[0];
      end
   end

   assign echo_s      = echo_p1;
   assign start_pulse = cmd[0] & ~cmd0_q;
   assign go          = start_pulse | cmd[1];
   assign busy        = (state != S_IDLE);
   assign unused_cmd  = ^cmd[7:2];

   // The ranging sequencer. trig and the result registers are driven
   // directly from here, so trig has no combinational path to the pin.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         pre      <= '0;
         cm       <= 8'd0;
         trig     <= 1'b0;
         distance <= 8'd0;
         valid    <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (go) begin
                  state   <= S_TRIG;
                  trig    <= 1'b1;
                  valid   <= 1'b0;
                  timeout <= 1'b0;
                  cnt     <= '0;
                  pre     <= '0;
                  cm      <= 8'd0;
               end
            end
            S_TRIG: begin
               if (cnt == TRIG_LAST) begin
                  trig  <= 1'b0;
                  state <= S_WAIT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT: begin
               // An echo that is already high on the first WAIT cycle counts
               // as an immediate rise. Pulses are not glitch filtered.
               if (echo_s) begin
                  state <= S_MEAS;
                  cnt   <= '0;
                  pre   <= '0;
                  cm    <= 8'd0;
               end else if (cnt == TIMEOUT_LAST) begin
                  timeout  <= 1'b1;
                  valid    <= 1'b0;
                  distance <= 8'hFF;
                  state    <= S_HOLD;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_MEAS: begin
               if (!echo_s) begin
                  distance <= cm;
                  valid    <= 1'b1;
                  state    <= S_HOLD;
                  cnt      <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  timeout  <= 1'b1;
                  valid    <= 1'b0;
                  distance <= 8'hFF;
                  state    <= S_HOLD;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
                  // pre divides echo clocks down to whole centimetres.
                  if (pre == PRE_LAST) begin
                     pre <= '0;
                     cm  <= sat_inc(cm);
                  end else begin
                     pre <= pre + 1'b1;
                  end
               end
            end
            S_HOLD: begin
               // A start edge that arrives here is dropped, not queued.
               if (cnt == HOLD_LAST) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               trig  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ultrasonic_range_ctrl.sv
// tb_ultrasonic_range_ctrl
// Scoreboard bench. The stimulus side pushes the expected result of each
// ranging cycle, and a negedge monitor pops and compares each completed
// result as the DUT presents it.
module tb_ultrasonic_range_ctrl;

   localparam int TRIG = 4;
   localparam int CPCM = 10;
   localparam int TMO  = 200;
   localparam int HOLD = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cmd = 8'h00;
   logic       echo = 1'b0;
   logic       trig;
   logic [7:0] distance;
   logic       valid;
   logic       timeout;
   logic       busy;

   logic [7:0] cmd_l = 8'h00;
   logic       echo_l = 1'b0;
   logic       trig_l;
   logic [7:0] distance_l;
   logic       valid_l;
   logic       timeout_l;
   logic       busy_l;

   always #5 clk = ~clk;

   ultrasonic_range_ctrl #(
      .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPCM),
      .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD)
   ) u_dut (
      .CLOCK_50(clk), .rst(rst), .cmd(cmd), .echo(echo), .trig(trig),
      .distance(distance), .valid(valid), .timeout(timeout), .busy(busy)
   );

   ultrasonic_range_ctrl #(
      .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPCM),
      .TIMEOUT_CYCLES(5000), .HOLDOFF_CYCLES(HOLD)
   ) u_dut_long (
      .CLOCK_50(clk), .rst(rst), .cmd(cmd_l), .echo(echo_l), .trig(trig_l),
      .distance(distance_l), .valid(valid_l), .timeout(timeout_l), .busy(busy_l)
   );

   typedef struct {
      int dlo;
      int dhi;
      bit v;
      bit t;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   trig_rises = 0;

   // Reference: echo of n clocks (0 = no echo) -> expected result.
   // The distance is floor(n/CPCM), and n may be off by one clock. A result
   // past the timeout limit reads as 255 with the timeout bit set.
   function automatic exp_t model(input int n);
      exp_t e;
      if (n == 0) begin
         e.dlo = 255; e.dhi = 255; e.v = 1'b0; e.t = 1'b1; e.lat = TMO;
      end else if (n > TMO) begin
         e.dlo = 255; e.dhi = 255; e.v = 1'b0; e.t = 1'b1; e.lat = -1;
      end else begin
         e.dlo = (n - 1) / CPCM;
         e.dhi = (n + 1) / CPCM;
         if (e.dlo > 255) e.dlo = 255;
         if (e.dhi > 255) e.dhi = 255;
         e.v = 1'b1; e.t = 1'b0; e.lat = -1;
      end
      return e;
   endfunction

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_busy_low(input int limit);
      int i = 0;
      while (busy && i < limit) begin
         tick(1);
         i++;
      end
      check_int("busy_low_wait", int'(busy), 0);
   endtask

   task automatic wait_trig_fall(input int limit);
      int i = 0;
      bit seen = 1'b0;
      while (i < limit) begin
         if (trig) seen = 1'b1;
         else if (seen) break;
         tick(1);
         i++;
      end
      check_int("trig_fall_wait", int'(seen && !trig), 1);
   endtask

   task automatic wait_valid(input int limit);
      int i = 0;
      while (!valid && i < limit) begin
         tick(1);
         i++;
      end
      check_int("valid_wait", int'(valid), 1);
   endtask

   task automatic run_shot(input int n, input int d);
      cmd = 8'h00;
      tick(1);
      sb.push_back(model(n));
      cmd = 8'h01;
      wait_trig_fall(50);
      tick(d);
      if (n > 0) begin
         echo = 1'b1;
         tick(n);
         echo = 1'b0;
      end
      wait_busy_low(1000);
      cmd = 8'h00;
      tick(1);
   endtask

   // Monitor: pops the scoreboard on every completed result and checks
   // the trigger width, the busy tail after a result and the timeout latency.
   initial begin
      bit   valid_q = 1'b0, timeout_q = 1'b0, trig_q = 1'b0, busy_q = 1'b0;
      bit   trig_abort = 1'b0, pend = 1'b0;
      int   trig_len = 0, t_tf = 0, t_done = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            pend = 1'b0;
            if (trig || trig_q) trig_abort = 1'b1;
         end
         if (trig === 1'b1) begin
            trig_len++;
            if (!trig_q) trig_rises++;
         end
         if (trig === 1'b0 && trig_q) begin
            t_tf = cyc;
            if (!trig_abort) check_int("trig_width", trig_len, TRIG);
            trig_len = 0;
            trig_abort = 1'b0;
         end
         if ((valid === 1'b1 && !valid_q) || (timeout === 1'b1 && !timeout_q)) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got distance %0d, want no result", distance);
            end else begin
               e = sb.pop_front();
               check_range("distance", int'(distance), e.dlo, e.dhi);
               check_int("valid", int'(valid), int'(e.v));
               check_int("timeout", int'(timeout), int'(e.t));
               if (e.lat >= 0) check_int("timeout_latency", cyc - t_tf, e.lat);
            end
            pend = 1'b1;
            t_done = cyc;
         end
         if (busy === 1'b0 && busy_q && pend) begin
            check_int("busy_tail", cyc - t_done, HOLD);
            pend = 1'b0;
         end
         valid_q   = (valid === 1'b1);
         timeout_q = (timeout === 1'b1);
         trig_q    = (trig === 1'b1);
         busy_q    = (busy === 1'b1);
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int n;
      int k;
      int i;

      // Reset state.
      tick(3);
      check_int("rst_trig", int'(trig), 0);
      check_int("rst_distance", int'(distance), 0);
      check_int("rst_valid", int'(valid), 0);
      check_int("rst_timeout", int'(timeout), 0);
      check_int("rst_busy", int'(busy), 0);
      rst = 1'b0;
      tick(2);

      // A single shot with a 123-clock echo gives 12 cm, and trig rises one clock after go.
      cmd = 8'h00;
      tick(1);
      sb.push_back(model(123));
      cmd = 8'h01;
      @(negedge clk);
      check_int("trig_before_go", int'(trig), 0);
      @(negedge clk);
      check_int("trig_latency", int'(trig), 1);
      check_int("busy_in_trig", int'(busy), 1);
      wait_trig_fall(50);
      tick(5);
      echo = 1'b1;
      tick(123);
      echo = 1'b0;
      wait_busy_low(1000);
      cmd = 8'h00;
      tick(1);

      // No echo: timeout after 200 clocks of waiting.
      run_shot(0, 0);

      // An echo longer than the timeout limit.
      run_shot(300, 3);

      // A long echo on the instance with the larger timeout: the distance saturates.
      cmd_l = 8'h01;
      i = 0;
      while (!trig_l && i < 20) begin tick(1); i++; end
      while (trig_l && i < 40) begin tick(1); i++; end
      check_int("long_trig_fall_wait", int'(trig_l), 0);
      echo_l = 1'b1;
      tick(3000);
      echo_l = 1'b0;
      i = 0;
      while (!valid_l && i < 20) begin tick(1); i++; end
      check_int("long_distance", int'(distance_l), 255);
      check_int("long_valid", int'(valid_l), 1);
      check_int("long_timeout", int'(timeout_l), 0);
      cmd_l = 8'h00;
      tick(2);

      // Continuous mode: four cycles, with cmd[1] cleared during the last one.
      base = trig_rises;
      cmd = 8'h02;
      for (int c = 0; c < 4; c++) begin
         sb.push_back(model(57));
         wait_trig_fall(100);
         tick($urandom_range(0, 20));
         echo = 1'b1;
         if (c == 3) begin
            tick(20);
            cmd = 8'h00;
            tick(37);
         end else begin
            tick(57);
         end
         echo = 1'b0;
      end
      wait_busy_low(1000);
      tick(40);
      check_int("cont_idle_busy", int'(busy), 0);
      check_int("cont_trig_count", trig_rises - base, 4);

      // A start edge during HOLD, then cmd[0] held high, gives only one shot.
      base = trig_rises;
      cmd = 8'h00;
      tick(1);
      sb.push_back(model(40));
      cmd = 8'h01;
      wait_trig_fall(50);
      tick(2);
      echo = 1'b1;
      tick(40);
      echo = 1'b0;
      wait_valid(20);
      cmd = 8'h00;
      tick(2);
      cmd = 8'h01;
      wait_busy_low(1000);
      tick(40);
      check_int("hold_start_trig_count", trig_rises - base, 1);
      check_int("hold_start_busy", int'(busy), 0);
      cmd = 8'h00;
      tick(2);

      // Reset while in TRIG.
      cmd = 8'h01;
      tick(2);
      rst = 1'b1;
      cmd = 8'h00;
      tick(1);
      check_int("rst_trig_state_trig", int'(trig), 0);
      check_int("rst_trig_state_busy", int'(busy), 0);
      check_int("rst_trig_state_valid", int'(valid), 0);
      check_int("rst_trig_state_distance", int'(distance), 0);
      rst = 1'b0;
      tick(2);

      // Reset while in MEAS, after an earlier result has set a nonzero distance.
      run_shot(77, 2);
      cmd = 8'h01;
      wait_trig_fall(50);
      tick(1);
      echo = 1'b1;
      tick(40);
      rst = 1'b1;
      cmd = 8'h00;
      tick(1);
      check_int("rst_meas_trig", int'(trig), 0);
      check_int("rst_meas_busy", int'(busy), 0);
      check_int("rst_meas_valid", int'(valid), 0);
      check_int("rst_meas_distance", int'(distance), 0);
      rst = 1'b0;
      tick(40);
      echo = 1'b0;
      tick(5);
      check_int("rst_meas_stays_idle", int'(busy), 0);

      // Randomised shots: normal echoes, missing echoes and over-long echoes.
      for (int r = 0; r < 12; r++) begin
         k = $urandom_range(0, 9);
         if (k < 2) n = 0;
         else if (k < 4) n = $urandom_range(230, 330);
         else n = $urandom_range(1, 190);
         run_shot(n, $urandom_range(0, 40));
      end

      tick(5);
      check_int("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
